motor_ramp_sequencer: RTL and testbench

Command sequencer between the APB-visible motor registers and the PWM/H-bridge outputs of the motor-control fabric. Per motor (left, right), it accepts target duty/direction commands and slews the applied duty toward target at a fixed rate. On a direction reversal it ramps to zero, holds the bridge in brake for a dead time, then ramps up in the new direction. It drives the 8-bit duty values consumed by the PWM generators and the 4-bit `inputsAB` bridge control.

---
 rtl/motor_ramp_sequencer_if.sv | 12 +
 rtl/motor_ramp_sequencer.sv | 121 ++++++++++++
 tb/tb_motor_ramp_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/motor_ramp_sequencer_if.sv
// motor_ramp_sequencer_if: command channel carrying one duty/direction request per cycle
// Signals: cmd_valid (strobe), cmd_ready (accept), cmd_motor (0 left, 1 right),
//          cmd_dir (0 forward, 1 reverse), cmd_duty (8-bit target duty)
interface motor_ramp_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_motor;
  logic       cmd_dir;
  logic [7:0] cmd_duty;
  modport master (output cmd_valid, cmd_motor, cmd_dir, cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, cmd_motor, cmd_dir, cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer: per-motor duty slew and reversal sequencing (ramp down, dead-time brake, ramp up)
// Ports: PCLK/PRESET clock and sync active-high reset; cmd command channel (slave);
//        estop emergency stop (used only when MOTOR_SEQ_ESTOP_EN is defined);
//        duty_left/duty_right applied duty; inputsAB bridge control [1:0] left, [3:2] right;
//        busy [0] left, [1] right, high when that motor is not idle.
module motor_ramp_sequencer #(
  parameter int STEP_DIV    = 1000,
  parameter int STEP        = 1,
  parameter int DEAD_CYCLES = 5000
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  motor_ramp_sequencer_if.slave       cmd,
  input  logic                        estop,
  output logic [7:0]                  duty_left,
  output logic [7:0]                  duty_right,
  output logic [3:0]                  inputsAB,
  output logic [1:0]                  busy
);
  localparam int CW = $clog2(STEP_DIV);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, DECEL, DEAD} st_e;
  // One ramp step from c toward t, clamped so the target is never overshot
  function automatic logic [7:0] toward(input logic [7:0] c, input logic [7:0] t);
    logic [8:0] d;
    d = (t > c) ? {1'b0, t} - {1'b0, c} : {1'b0, c} - {1'b0, t};
    d = (d > 9'(STEP)) ? 9'(STEP) : d;
    return (t > c) ? 8'({1'b0, c} + d) : 8'({1'b0, c} - d);
  endfunction
  logic          stop;
`ifdef MOTOR_SEQ_ESTOP_EN
  assign stop = estop;
`else
  logic unused_estop;
  assign unused_estop = estop;
  assign stop = 1'b0;
`endif
  logic [CW-1:0] cnt_q;
  logic          tick;
  logic          ready_q;
  logic          accept;
  logic [15:0]   duty_all;
  assign tick          = cnt_q == CW'(STEP_DIV - 1);
  assign accept        = cmd.cmd_valid && ready_q && !stop;
  assign cmd.cmd_ready = ready_q;
  assign duty_left     = duty_all[7:0];
  assign duty_right    = duty_all[15:8];
  always_ff @(posedge PCLK) begin
    cnt_q   <= (PRESET || tick) ? '0 : cnt_q + 1'b1;
    ready_q <= !PRESET && !stop;
  end
  for (genvar m = 0; m < 2; m++) begin : g_mot
    st_e           st_q, st_d;
    logic [7:0]    duty_q, duty_d, tgt_q, tgt_d;
    logic          dir_q, dir_d, tdir_q, tdir_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [1:0]    ab_q, ab_d;
    logic          acc;
    assign acc = accept && cmd.cmd_motor == 1'(m);
    always_comb begin
      st_d   = st_q;
      duty_d = duty_q;
      dir_d  = dir_q;
      dcnt_d = dcnt_q;
      tgt_d  = acc ? cmd.cmd_duty : tgt_q;
      tdir_d = acc ? cmd.cmd_dir : tdir_q;
      case (st_q)
        IDLE: if (acc && cmd.cmd_duty != 8'd0) begin
          st_d   = (cmd.cmd_dir == dir_q) ? RUN : DEAD;
          dcnt_d = DW'(DEAD_CYCLES - 1);
        end
        // the ramp uses the pre-accept target so a coincident command takes effect next tick
        RUN: begin
          duty_d = tick ? toward(duty_q, tgt_q) : duty_q;
          st_d   = (acc && cmd.cmd_dir != dir_q) ? DECEL : (duty_d == 8'd0 && tgt_d == 8'd0) ? IDLE : RUN;
        end
        // leave for DEAD on the same edge duty hits zero so the brake window is exactly DEAD_CYCLES
        DECEL: begin
          duty_d = tick ? toward(duty_q, 8'd0) : duty_q;
          st_d   = (acc && cmd.cmd_dir == dir_q) ? RUN : (duty_d == 8'd0) ? DEAD : DECEL;
          dcnt_d = DW'(DEAD_CYCLES - 1);
        end
        DEAD: begin
          duty_d = 8'd0;
          dcnt_d = (dcnt_q == '0) ? dcnt_q : dcnt_q - 1'b1;
          dir_d  = (dcnt_q == '0) ? tdir_d : dir_q;
          st_d   = (dcnt_q != '0) ? DEAD : (tgt_d != 8'd0) ? RUN : IDLE;
        end
      endcase
      if (stop) begin
        st_d   = DEAD;
        duty_d = 8'd0;
        tgt_d  = 8'd0;
        dcnt_d = DW'(DEAD_CYCLES - 1);
      end
      ab_d = (st_d == RUN || st_d == DECEL) ? {~dir_d, dir_d} : 2'b00;
    end
    always_ff @(posedge PCLK) begin
      if (PRESET) begin
        st_q   <= IDLE;
        duty_q <= '0;
        dir_q  <= 1'b0;
        tgt_q  <= '0;
        tdir_q <= 1'b0;
        dcnt_q <= '0;
        ab_q   <= 2'b00;
      end else begin
        st_q   <= st_d;
        duty_q <= duty_d;
        dir_q  <= dir_d;
        tgt_q  <= tgt_d;
        tdir_q <= tdir_d;
        dcnt_q <= dcnt_d;
        ab_q   <= ab_d;
      end
    end
    assign duty_all[8*m +: 8] = duty_q;
    assign inputsAB[2*m +: 2] = ab_q;
    assign busy[m]            = st_q != IDLE;
  end
endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// tb_motor_ramp_sequencer: directed checks of ramping, reversal, cancel, independence and reset
module tb_motor_ramp_sequencer;
  logic       clk = 1'b0;
  logic       PRESET = 1'b1;
  logic       estop = 1'b0;
  logic [7:0] duty_left, duty_right;
  logic [3:0] inputsAB;
  logic [1:0] busy;
  int         n_chk = 0;
  int         n_fail = 0;
  int         pe = 0;
  motor_ramp_sequencer_if bus ();
  motor_ramp_sequencer #(.STEP_DIV(4), .STEP(16), .DEAD_CYCLES(8)) dut (
    .PCLK(clk), .PRESET(PRESET), .cmd(bus), .estop(estop),
    .duty_left(duty_left), .duty_right(duty_right), .inputsAB(inputsAB), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) pe <= PRESET ? 0 : pe + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic do_reset();
    @(negedge clk);
    PRESET = 1'b1;
    estop = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    PRESET = 1'b0;
  endtask
  task automatic send(input logic m, input logic d, input logic [7:0] duty);
    bus.cmd_valid = 1'b1;
    bus.cmd_motor = m;
    bus.cmd_dir = d;
    bus.cmd_duty = duty;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_chk++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", bus.cmd_ready); end
    n_chk++; if ({duty_left, duty_right} !== 16'h0) begin n_fail++; $display("FAIL reset_duty got %h exp 0000", {duty_left, duty_right}); end
    n_chk++; if (inputsAB !== 4'b0000) begin n_fail++; $display("FAIL reset_ab got %b exp 0000", inputsAB); end
    n_chk++; if (busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy got %b exp 00", busy); end
    @(negedge clk);
    n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b exp 1", bus.cmd_ready); end
    repeat (6) @(negedge clk);
    n_chk++; if ({duty_left, duty_right, inputsAB, busy} !== 22'h0) begin n_fail++; $display("FAIL idle_outputs got %h exp 0", {duty_left, duty_right, inputsAB, busy}); end
  endtask
  task automatic test_left_fwd();
    int e;
    do_reset();
    @(negedge clk);
    send(1'b0, 1'b0, 8'd64);
    n_chk++; if (inputsAB !== 4'b0010 || busy !== 2'b01) begin n_fail++; $display("FAIL fwd_start ab=%b busy=%b exp 0010/01", inputsAB, busy); end
    n_chk++; if (duty_left !== 8'd0) begin n_fail++; $display("FAIL fwd_no_early_step got %0d exp 0", duty_left); end
    while (pe < 20) begin
      @(negedge clk);
      e = pe < 4 ? 0 : pe < 8 ? 16 : pe < 12 ? 32 : pe < 16 ? 48 : 64;
      n_chk++; if (duty_left !== 8'(e)) begin n_fail++; $display("FAIL fwd_ramp pe=%0d got %0d exp %0d", pe, duty_left, e); end
    end
    n_chk++; if (duty_right !== 8'd0 || inputsAB !== 4'b0010) begin n_fail++; $display("FAIL fwd_right_quiet duty=%0d ab=%b exp 0/0010", duty_right, inputsAB); end
  endtask
  task automatic test_right_ramp();
    int e;
    do_reset();
    @(negedge clk);
    send(1'b1, 1'b0, 8'd40);
    while (pe < 13) begin
      @(negedge clk);
      e = pe < 4 ? 0 : pe < 8 ? 16 : pe < 12 ? 32 : 40;
      n_chk++; if (duty_right !== 8'(e)) begin n_fail++; $display("FAIL right_up pe=%0d got %0d exp %0d", pe, duty_right, e); end
    end
    send(1'b1, 1'b0, 8'd0);
    while (pe < 26) begin
      @(negedge clk);
      e = pe < 16 ? 40 : pe < 20 ? 24 : pe < 24 ? 8 : 0;
      n_chk++; if (duty_right !== 8'(e)) begin n_fail++; $display("FAIL right_down pe=%0d got %0d exp %0d", pe, duty_right, e); end
      n_chk++; if (busy[1] !== (pe < 24) || inputsAB[3:2] !== (pe < 24 ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL right_idle pe=%0d busy=%b ab=%b", pe, busy, inputsAB); end
    end
    n_chk++; if (duty_left !== 8'd0 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL right_left_quiet duty=%0d busy=%b", duty_left, busy); end
  endtask
  task automatic test_left_reversal();
    int e;
    int brake = 0;
    logic [1:0] eab;
    do_reset();
    @(negedge clk);
    send(1'b0, 1'b0, 8'd64);
    while (pe < 17) @(negedge clk);
    n_chk++; if (duty_left !== 8'd64) begin n_fail++; $display("FAIL rev_pre got %0d exp 64", duty_left); end
    send(1'b0, 1'b1, 8'd48);
    while (pe < 56) begin
      @(negedge clk);
      e = pe < 20 ? 64 : pe < 24 ? 48 : pe < 28 ? 32 : pe < 32 ? 16 : pe < 44 ? 0 : pe < 48 ? 16 : pe < 52 ? 32 : 48;
      eab = pe < 32 ? 2'b10 : pe < 40 ? 2'b00 : 2'b01;
      brake += (inputsAB[1:0] == 2'b00) ? 1 : 0;
      n_chk++; if (duty_left !== 8'(e)) begin n_fail++; $display("FAIL rev_duty pe=%0d got %0d exp %0d", pe, duty_left, e); end
      n_chk++; if (inputsAB[1:0] !== eab) begin n_fail++; $display("FAIL rev_bridge pe=%0d got %b exp %b", pe, inputsAB[1:0], eab); end
    end
    n_chk++; if (brake != 8) begin n_fail++; $display("FAIL rev_brake_len got %0d exp 8", brake); end
  endtask
  task automatic test_cancel();
    int e;
    do_reset();
    @(negedge clk);
    send(1'b0, 1'b0, 8'd64);
    while (pe < 17) @(negedge clk);
    send(1'b0, 1'b1, 8'd64);
    while (pe < 34) begin
      if (pe == 25) send(1'b0, 1'b0, 8'd64);
      else @(negedge clk);
      e = pe < 20 ? 64 : pe < 24 ? 48 : pe < 28 ? 32 : pe < 32 ? 48 : 64;
      n_chk++; if (duty_left !== 8'(e)) begin n_fail++; $display("FAIL cancel_duty pe=%0d got %0d exp %0d", pe, duty_left, e); end
      n_chk++; if (inputsAB !== 4'b0010 || busy !== 2'b01) begin n_fail++; $display("FAIL cancel_bridge pe=%0d ab=%b busy=%b exp 0010/01", pe, inputsAB, busy); end
    end
  endtask
  task automatic test_back_to_back();
    int el, er;
    logic [3:0] eab;
    do_reset();
    @(negedge clk);
    send(1'b0, 1'b0, 8'd32);
    send(1'b1, 1'b1, 8'd32);
    n_chk++; if (busy !== 2'b11 || inputsAB !== 4'b0010) begin n_fail++; $display("FAIL b2b_start busy=%b ab=%b exp 11/0010", busy, inputsAB); end
    while (pe < 18) begin
      @(negedge clk);
      el = pe < 4 ? 0 : pe < 8 ? 16 : 32;
      er = pe < 12 ? 0 : pe < 16 ? 16 : 32;
      eab = pe < 11 ? 4'b0010 : 4'b0110;
      n_chk++; if (duty_left !== 8'(el) || duty_right !== 8'(er)) begin n_fail++; $display("FAIL b2b_duty pe=%0d got %0d/%0d exp %0d/%0d", pe, duty_left, duty_right, el, er); end
      n_chk++; if (inputsAB !== eab) begin n_fail++; $display("FAIL b2b_bridge pe=%0d got %b exp %b", pe, inputsAB, eab); end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    send(1'b0, 1'b0, 8'd64);
    while (pe < 9) @(negedge clk);
    n_chk++; if (duty_left !== 8'd32) begin n_fail++; $display("FAIL mid_pre got %0d exp 32", duty_left); end
    PRESET = 1'b1;
    @(negedge clk);
    n_chk++; if ({duty_left, duty_right, inputsAB, busy, bus.cmd_ready} !== 23'h0) begin n_fail++; $display("FAIL mid_reset got %h exp 0", {duty_left, duty_right, inputsAB, busy, bus.cmd_ready}); end
    PRESET = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++; if (bus.cmd_ready !== 1'b1 || busy !== 2'b00 || duty_left !== 8'd0) begin n_fail++; $display("FAIL mid_after ready=%b busy=%b duty=%0d", bus.cmd_ready, busy, duty_left); end
  endtask
`ifdef MOTOR_SEQ_ESTOP_EN
  task automatic test_estop();
    logic [1:0] eb;
    do_reset();
    @(negedge clk);
    send(1'b0, 1'b0, 8'd64);
    send(1'b1, 1'b0, 8'd64);
    while (pe < 9) @(negedge clk);
    n_chk++; if (duty_left !== 8'd32 || duty_right !== 8'd32) begin n_fail++; $display("FAIL estop_pre got %0d/%0d exp 32/32", duty_left, duty_right); end
    estop = 1'b1;
    @(negedge clk);
    estop = 1'b0;
    n_chk++; if ({duty_left, duty_right, inputsAB, bus.cmd_ready} !== 21'h0 || busy !== 2'b11) begin n_fail++; $display("FAIL estop_hit duty=%0d/%0d ab=%b ready=%b busy=%b", duty_left, duty_right, inputsAB, bus.cmd_ready, busy); end
    while (pe < 19) begin
      @(negedge clk);
      eb = pe < 18 ? 2'b11 : 2'b00;
      n_chk++; if (busy !== eb || inputsAB !== 4'b0000) begin n_fail++; $display("FAIL estop_dead pe=%0d busy=%b ab=%b exp %b/0000", pe, busy, inputsAB, eb); end
    end
    n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL estop_ready got %b exp 1", bus.cmd_ready); end
  endtask
`endif
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_motor = 1'b0;
    bus.cmd_dir = 1'b0;
    bus.cmd_duty = 8'd0;
    test_reset();
    test_left_fwd();
    test_right_ramp();
    test_left_reversal();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
`ifdef MOTOR_SEQ_ESTOP_EN
    test_estop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
